// File: rtl/rm_index_map_pkg.sv
// rm_index_map_pkg -- shared types and constants for the random-modulo index map.
//   rm_seed_t  : placement seed / PRNG word
//   rm_state_t : reseed FSM states
//   RM_*_W     : default widths (16-bit seed, 64 sets, 20-bit tag)
package rm_index_map_pkg;

    localparam int RM_SEED_W = 16;
    localparam int RM_IDX_W  = 6;
    localparam int RM_TAG_W  = 20;

    typedef logic [RM_SEED_W-1:0] rm_seed_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        LATCH
    } rm_state_t;

endpackage

// File: rtl/rm_index_map_if.sv
// rm_index_map_if -- lookup request / mapped-index response bundle.
//   req_valid/req_ready/req_tag/req_index : request handshake (master drives valid/tag/index)
//   resp_valid/resp_index                  : mapped index, no backpressure
// master = cache tag-lookup side, slave = rm_index_map.
interface rm_index_map_if #(
    parameter int IDX_W = rm_index_map_pkg::RM_IDX_W,
    parameter int TAG_W = rm_index_map_pkg::RM_TAG_W
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic             resp_valid;
    logic [IDX_W-1:0] resp_index;

    modport master (
        output req_valid, req_tag, req_index,
        input  req_ready, resp_valid, resp_index
    );

    modport slave (
        input  req_valid, req_tag, req_index,
        output req_ready, resp_valid, resp_index
    );
endinterface

// File: rtl/rm_index_map_hash.sv
// rm_index_hash -- combinational tag/seed fold for the index map.
//   tag  : request tag
//   seed : active placement seed
//   key  : XOR mask applied after rotation (tag fold ^ seed low bits)
//   rot  : rotate amount, already reduced modulo IDX_W
// The fold bit positions assume a 20-bit tag and 6-bit index.
module rm_index_hash
    import rm_index_map_pkg::*;
#(
    parameter int SEED_W = RM_SEED_W,
    parameter int IDX_W  = RM_IDX_W,
    parameter int TAG_W  = RM_TAG_W,
    parameter int ROT_W  = $clog2(RM_IDX_W)
) (
    input  logic [TAG_W-1:0]  tag,
    input  logic [SEED_W-1:0] seed,
    output logic [IDX_W-1:0]  key,
    output logic [ROT_W-1:0]  rot
);
    logic [IDX_W-1:0] tf6;
    logic [7:0]       tf8;
    logic [7:0]       rot_raw;

    assign tf6 = tag[5:0] ^ tag[11:6] ^ tag[17:12] ^ {4'b0, tag[19:18]};
    assign tf8 = tag[7:0] ^ tag[15:8] ^ {4'b0, tag[19:16]};

    assign key     = tf6 ^ seed[IDX_W-1:0];
    assign rot_raw = tf8 ^ seed[SEED_W-1:SEED_W-8];
    // Non-power-of-two modulus; result is always < IDX_W so it fits ROT_W.
    assign rot     = ROT_W'(rot_raw % 8'(IDX_W));

    // Seed bits between the key slice and the rotate slice do not feed the hash.
    logic unused_seed_bits;
    assign unused_seed_bits = ^seed[SEED_W-9:IDX_W];

endmodule

// File: rtl/rm_index_map.sv
// rm_index_map -- consumer of the L1 random-modulo PRNG stream.
// Maps (tag, set index) to a randomized set index through a 2-stage pipeline
// and runs the reseed sequence IDLE -> DRAIN -> FLUSH -> LATCH.
//   clk, reset  : clock, asynchronous active-high reset
//   rand_i      : free-running PRNG word, latched as the new seed in LATCH
//   bus         : request/response bundle (slave side)
//   reseed_req  : pulse, start a reseed (only honoured in IDLE)
//   flush_req   : level, asks the cache to invalidate all lines
//   flush_done  : pulse, flush complete (only honoured in FLUSH)
//   reseed_done : pulse, new seed active
// Optional: RM_SEED_PARITY_EN adds a stored seed parity bit and a sticky
// seed_par_err output that keeps forcing reseeds while set.
module rm_index_map
    import rm_index_map_pkg::*;
#(
    parameter int                SEED_W     = RM_SEED_W,
    parameter int                IDX_W      = RM_IDX_W,
    parameter int                TAG_W      = RM_TAG_W,
    parameter logic [SEED_W-1:0] SEED_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] rand_i,
    rm_index_map_if.slave     bus,
    input  logic              reseed_req,
    output logic              flush_req,
    input  logic              flush_done,
    output logic              reseed_done
`ifdef RM_SEED_PARITY_EN
    ,
    output logic              seed_par_err
`endif
);
    localparam int ROT_W  = $clog2(IDX_W);
    localparam int STAGES = 2;

    rm_state_t         state_q, state_d;
    logic [SEED_W-1:0] seed_q;
    logic              accept;
    logic              reseed_go;

    logic [STAGES:1]   vld_pipe;
    logic [IDX_W-1:0]  h_key, s1_key, s1_index, resp_index_q;
    logic [ROT_W-1:0]  h_rot, s1_rot;

    function automatic logic [IDX_W-1:0] rotl(input logic [IDX_W-1:0] v,
                                              input logic [ROT_W-1:0] r);
        logic [2*IDX_W-1:0] dbl;
        dbl = {v, v} << r;
        return dbl[2*IDX_W-1:IDX_W];
    endfunction

    // ---------------- seed parity (optional) ----------------
`ifdef RM_SEED_PARITY_EN
    logic par_q, par_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q     <= ^SEED_RESET;
            par_err_q <= 1'b0;
        end else begin
            if (state_q == LATCH)
                par_q <= ^rand_i;
            // Sticky: a corrupted seed keeps forcing reseeds until reset.
            if ((^seed_q) != par_q)
                par_err_q <= 1'b1;
        end
    end

    assign seed_par_err = par_err_q;
    assign reseed_go    = reseed_req | par_err_q;
`else
    assign reseed_go    = reseed_req;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reseed_go)       state_d = DRAIN;
            DRAIN:   if (vld_pipe == '0)  state_d = FLUSH;
            FLUSH:   if (flush_done)      state_d = LATCH;
            LATCH:                        state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = 1'b0;
        flush_req     = 1'b0;
        reseed_done   = 1'b0;
        case (state_q)
            IDLE:    bus.req_ready = 1'b1;
            FLUSH:   flush_req     = 1'b1;
            LATCH:   reseed_done   = 1'b1;
            default: ;
        endcase
    end

    // Seed only moves in LATCH, after the pipeline has drained, so every
    // in-flight request is mapped with a single seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  seed_q <= SEED_RESET;
        else if (state_q == LATCH)  seed_q <= rand_i;
    end

    // ---------------- pipeline ----------------
    assign accept = bus.req_valid & bus.req_ready;

    rm_index_hash #(
        .SEED_W (SEED_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .ROT_W  (ROT_W)
    ) u_hash (
        .tag  (bus.req_tag),
        .seed (seed_q),
        .key  (h_key),
        .rot  (h_rot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe     <= '0;
            s1_index     <= '0;
            s1_key       <= '0;
            s1_rot       <= '0;
            resp_index_q <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept) begin
                s1_index <= bus.req_index;
                s1_key   <= h_key;
                s1_rot   <= h_rot;
            end
            if (vld_pipe[1])
                resp_index_q <= rotl(s1_index, s1_rot) ^ s1_key;
        end
    end

    assign bus.resp_valid = vld_pipe[STAGES];
    assign bus.resp_index = resp_index_q;

endmodule

// File: tb/tb_rm_index_map.sv
// tb_rm_index_map -- self-checking bench for rm_index_map. Expected indices
// come from an integer-arithmetic model of the mapping rules; responses are
// collected per cycle and compared against index and arrival cycle.
module tb_rm_index_map;
    import rm_index_map_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    rm_seed_t rand_i;
    logic     reseed_req, flush_done;
    logic     flush_req, reseed_done;
`ifdef RM_SEED_PARITY_EN
    logic     seed_par_err;
`endif

    rm_index_map_if bus();

    rm_index_map dut (
        .clk         (clk),
        .reset       (reset),
        .rand_i      (rand_i),
        .bus         (bus),
        .reseed_req  (reseed_req),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .reseed_done (reseed_done)
`ifdef RM_SEED_PARITY_EN
        ,
        .seed_par_err(seed_par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int cyc; } resp_t;

    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    int    exp_seed   = 0;
    resp_t got_q[$];

    // Reference mapping written from the rules with plain integer arithmetic.
    function automatic int model_map(int tag, int idx, int seed);
        int tf6, tf8, key, rot, r;
        tf6 = (tag & 63) ^ ((tag >> 6) & 63) ^ ((tag >> 12) & 63) ^ ((tag >> 18) & 3);
        tf8 = (tag & 255) ^ ((tag >> 8) & 255) ^ ((tag >> 16) & 15);
        key = tf6 ^ (seed & 63);
        rot = (tf8 ^ ((seed >> 8) & 255)) % 6;
        r   = ((idx << rot) | (idx >> (6 - rot))) & 63;
        return r ^ key;
    endfunction

    // Advance one clock and record any response seen just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.resp_valid === 1'b1)
            got_q.push_back('{idx: int'(bus.resp_index), cyc: cyc});
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_tag   = '0;
        bus.req_index = '0;
        reseed_req    = 1'b0;
        flush_done    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rand_i = 16'hA5A5;
        reset  = 1'b1;
        #3;
        compared++;
        if (bus.resp_valid !== 1'b0 || flush_req !== 1'b0 || reseed_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: resp_valid=%b flush_req=%b reseed_done=%b want 0/0/0",
                     bus.resp_valid, flush_req, reseed_done);
        end
        compared++;
        if (bus.resp_index !== 6'd0) begin
            mismatched++;
            $display("FAIL reset_resp_index: got %0d want 0", bus.resp_index);
        end
        step(); step();
        reset = 1'b0;
        got_q.delete();
        exp_seed = 0;
        compared++;
        if (bus.req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
`ifdef RM_SEED_PARITY_EN
        compared++;
        if (seed_par_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_par_err: got %b want 0", seed_par_err);
        end
`endif
    endtask

    task automatic test_default_map();
        int c;
        bus.req_valid = 1'b1; bus.req_tag = '0; bus.req_index = 6'd5;
        c = cyc;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (got_q.size() != 1) begin
            mismatched++;
            $display("FAIL default_map_count: got %0d responses want 1", got_q.size());
        end
        if (got_q.size() >= 1) begin
            compared++;
            if (got_q[0].idx != 5 || got_q[0].cyc != c + 2) begin
                mismatched++;
                $display("FAIL default_map: got idx %0d at +%0d want idx 5 at +2",
                         got_q[0].idx, got_q[0].cyc - c);
            end
        end
        got_q.delete();
    endtask

    task automatic test_permutation();
        int        c;
        logic [19:0] tag;
        logic [63:0] seen;
        tag  = 20'($urandom);
        seen = '0;
        c    = cyc;
        for (int i = 0; i < 64; i++) begin
            bus.req_valid = 1'b1; bus.req_tag = tag; bus.req_index = 6'(i);
            step();
        end
        bus.req_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (got_q.size() != 64) begin
            mismatched++;
            $display("FAIL perm_count: got %0d responses want 64", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            compared++;
            if (got_q[k].idx != model_map(int'(tag), k, exp_seed) || got_q[k].cyc != c + 2 + k) begin
                mismatched++;
                $display("FAIL perm_resp[%0d]: got idx %0d cyc %0d want idx %0d cyc %0d",
                         k, got_q[k].idx, got_q[k].cyc, model_map(int'(tag), k, exp_seed), c + 2 + k);
            end
            seen[got_q[k].idx] = 1'b1;
        end
        compared++;
        if (seen !== {64{1'b1}}) begin
            mismatched++;
            $display("FAIL perm_cover: got set %h want all ones", seen);
        end
        got_q.delete();
    endtask

    task automatic test_random_traffic(input int n);
        resp_t       exp_q[$];
        logic [19:0] tag;
        logic [5:0]  idx;
        for (int i = 0; i < n; i++) begin
            bus.req_valid = ($urandom_range(0, 2) != 0);
            tag = 20'($urandom);
            idx = 6'($urandom);
            bus.req_tag = tag; bus.req_index = idx;
            if (bus.req_valid)
                exp_q.push_back('{idx: model_map(int'(tag), int'(idx), exp_seed), cyc: cyc + 2});
            step();
        end
        bus.req_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (got_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL random_count: got %0d responses want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            compared++;
            if (got_q[k].idx != exp_q[k].idx || got_q[k].cyc != exp_q[k].cyc) begin
                mismatched++;
                $display("FAIL random_resp[%0d]: got idx %0d cyc %0d want idx %0d cyc %0d",
                         k, got_q[k].idx, got_q[k].cyc, exp_q[k].idx, exp_q[k].cyc);
            end
        end
        got_q.delete();
    endtask

    // Full reseed with a decoy on rand_i except in the LATCH cycle.
    task automatic test_flush_handshake(input rm_seed_t val);
        int f;
        bit seen;
        rand_i     = ~val;
        reseed_req = 1'b1;
        step();
        reseed_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (flush_req === 1'b1) seen = 1;
            else step();
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL flush_req_timeout: got flush_req=%b want 1 within 20 cycles", flush_req);
        end
        f = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (flush_req !== 1'b1 || reseed_done !== 1'b0) f++;
        end
        compared++;
        if (f != 0) begin
            mismatched++;
            $display("FAIL flush_hold: got %0d bad cycles want 0", f);
        end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        rand_i     = val;
        compared++;
        if (reseed_done !== 1'b1) begin
            mismatched++;
            $display("FAIL reseed_done_pulse: got %b want 1", reseed_done);
        end
        step();
        rand_i = 16'($urandom);
        compared++;
        if (reseed_done !== 1'b0 || bus.req_ready !== 1'b1 || flush_req !== 1'b0) begin
            mismatched++;
            $display("FAIL after_latch: reseed_done=%b req_ready=%b flush_req=%b want 0/1/0",
                     reseed_done, bus.req_ready, flush_req);
        end
        exp_seed = int'(val);
        got_q.delete();
    endtask

    task automatic test_loaded_seed();
        int c;
        bus.req_valid = 1'b1; bus.req_tag = '0; bus.req_index = 6'h05;
        c = cyc;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (got_q.size() != 1 || got_q[0].idx != 9 || got_q[0].cyc != c + 2) begin
            mismatched++;
            $display("FAIL loaded_seed_map: got %0d responses, first idx %0d want 1 response idx 9 at +2",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].idx : -1);
        end
        got_q.delete();
    endtask

    task automatic test_reseed_inflight();
        int          c, rise, old_seed, extra;
        logic [19:0] ta, tb;
        logic [5:0]  ia, ib;
        rm_seed_t    nv;
        old_seed = exp_seed;
        nv = 16'($urandom) | 16'h0001;
        ta = 20'($urandom); ia = 6'($urandom);
        tb = 20'($urandom); ib = 6'($urandom);
        rand_i = ~nv;
        c = cyc;
        bus.req_valid = 1'b1; bus.req_tag = ta; bus.req_index = ia;
        step();
        bus.req_tag = tb; bus.req_index = ib; reseed_req = 1'b1;
        step();
        bus.req_valid = 1'b0; reseed_req = 1'b0;
        compared++;
        if (bus.req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_ready: got %b want 0", bus.req_ready);
        end
        rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            if (flush_req === 1'b1) rise = cyc;
            else step();
        end
        compared++;
        if (rise <= c + 3) begin
            mismatched++;
            $display("FAIL flush_rise: got cycle +%0d want after +3 (pipeline empty)", rise - c);
        end
        compared++;
        if (got_q.size() != 2 ||
            got_q[0].idx != model_map(int'(ta), int'(ia), old_seed) || got_q[0].cyc != c + 2 ||
            got_q[1].idx != model_map(int'(tb), int'(ib), old_seed) || got_q[1].cyc != c + 3) begin
            mismatched++;
            $display("FAIL inflight_old_seed: got %0d responses want 2 mapped with seed %h",
                     got_q.size(), old_seed);
        end
        got_q.delete();
        // Second reseed_req while flushing must not queue another reseed.
        reseed_req = 1'b1;
        step();
        reseed_req = 1'b0;
        step();
        rand_i = nv;
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        compared++;
        if (reseed_done !== 1'b1) begin
            mismatched++;
            $display("FAIL inflight_reseed_done: got %b want 1", reseed_done);
        end
        step();
        rand_i = 16'($urandom);
        exp_seed = int'(nv);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (flush_req !== 1'b0 || reseed_done !== 1'b0 || bus.req_ready !== 1'b1) extra++;
            step();
        end
        compared++;
        if (extra != 0) begin
            mismatched++;
            $display("FAIL ignored_reseed: got %0d non-idle cycles want 0", extra);
        end
    endtask

    task automatic test_stray_flush_done();
        int bad;
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (flush_req !== 1'b0 || reseed_done !== 1'b0 || bus.req_ready !== 1'b1) bad++;
            step();
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL stray_flush_done: got %0d non-idle cycles want 0", bad);
        end
        test_random_traffic(12);
    endtask

    task automatic test_reset_mid_flush();
        bit          seen;
        int          c;
        logic [19:0] tag;
        logic [5:0]  idx;
        reseed_req = 1'b1;
        step();
        reseed_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (flush_req === 1'b1) seen = 1;
            else step();
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL midflush_timeout: got flush_req=%b want 1 within 20 cycles", flush_req);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (flush_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL midflush_reset: flush_req=%b resp_valid=%b req_ready=%b want 0/0/1",
                     flush_req, bus.resp_valid, bus.req_ready);
        end
        step();
        reset = 1'b0;
        got_q.delete();
        exp_seed = 0;
        tag = 20'($urandom); idx = 6'($urandom);
        bus.req_valid = 1'b1; bus.req_tag = tag; bus.req_index = idx;
        c = cyc;
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (got_q.size() != 1 || got_q[0].idx != model_map(int'(tag), int'(idx), 0) || got_q[0].cyc != c + 2) begin
            mismatched++;
            $display("FAIL midflush_reset_seed: got %0d responses, first idx %0d want idx %0d",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].idx : -1, model_map(int'(tag), int'(idx), 0));
        end
        got_q.delete();
    endtask

`ifdef RM_SEED_PARITY_EN
    task automatic test_parity();
        logic [15:0] bad_seed;
        bit          seen;
        bad_seed = dut.seed_q ^ 16'h0001;
        force dut.seed_q = bad_seed;
        step();
        release dut.seed_q;
        compared++;
        if (seed_par_err !== 1'b1) begin
            mismatched++;
            $display("FAIL par_err: got %b want 1", seed_par_err);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (flush_req === 1'b1) seen = 1;
            else step();
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL par_forced_flush: got flush_req=%b want 1 within 20 cycles", flush_req);
        end
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        compared++;
        if (reseed_done !== 1'b1 || seed_par_err !== 1'b1) begin
            mismatched++;
            $display("FAIL par_reseed: reseed_done=%b par_err=%b want 1/1", reseed_done, seed_par_err);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        got_q.delete();
        exp_seed = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_default_map();
        test_permutation();
        test_random_traffic(40);
        test_flush_handshake(16'h0103);
        test_loaded_seed();
        test_random_traffic(30);
        test_reseed_inflight();
        test_random_traffic(30);
        test_stray_flush_done();
        test_reset_mid_flush();
`ifdef RM_SEED_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/rm_index_map.md
Name: rm_index_map

Overview:
- Consumer end of the L1 random-modulo PRNG stream.
- Holds the active placement seed and maps each (tag, set index) request to a randomized set index through a 2-stage pipeline.
- Runs a reseed FSM: drains the pipeline, requests a cache flush, then latches a fresh PRNG word as the new seed.
- One instance sits beside each L1 cache's tag-lookup path.

Parameters:
- SEED_W, 16, width of seed and of rand_i; must match the PRNG's NNUM.
- IDX_W, 6, set-index width (64 sets).
- TAG_W, 20, tag width.
- SEED_RESET, 16'h0000, seed value loaded at reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rand_i  in  SEED_W  free-running PRNG output
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted; high only in IDLE
- req_tag  in  TAG_W  request tag
- req_index  in  IDX_W  unmapped set index
- resp_valid  out  1  mapped index valid
- resp_index  out  IDX_W  mapped set index
- reseed_req  in  1  single-cycle pulse; start a reseed
- flush_req  out  1  level; asks the cache to invalidate all lines
- flush_done  in  1  single-cycle pulse; flush complete
- reseed_done  out  1  single-cycle pulse; new seed active

Behaviour:
- Arithmetic, all unsigned:
  - tf6 = tag[5:0] ^ tag[11:6] ^ tag[17:12] ^ {4'b0, tag[19:18]}
  - tf8 = tag[7:0] ^ tag[15:8] ^ {4'b0, tag[19:16]}
  - key = tf6 ^ seed[IDX_W-1:0]
  - rot = (tf8 ^ seed[SEED_W-1:SEED_W-8]) mod IDX_W
  - resp_index = rotl(req_index, rot) ^ key, rotation within IDX_W bits
  - For a fixed tag and seed, the map is a bijection on the index.
- Pipeline:
  - A request is accepted when req_valid & req_ready.
  - Stage 1 registers valid, index, key and rot, using the seed current in that cycle.
  - Stage 2 registers resp_valid and resp_index.
  - Latency is exactly 2 cycles. Full throughput of 1 per cycle. No response backpressure.
- FSM states: IDLE, DRAIN, FLUSH, LATCH.
  - IDLE: reseed_req -> DRAIN. A request presented in the same cycle as reseed_req is still accepted.
  - DRAIN: req_ready=0. When both pipeline stages are empty -> FLUSH.
  - FLUSH: flush_req=1. On flush_done -> LATCH. flush_done received outside FLUSH is ignored.
  - LATCH: seed <= rand_i, reseed_done=1 for this cycle, then -> IDLE.
  - reseed_req outside IDLE is ignored; it is not queued.
- Reset, asynchronous:
  - seed=SEED_RESET; FSM=IDLE; both stage valids cleared.
  - resp_valid=0, resp_index=0, flush_req=0, reseed_done=0.
  - req_ready=1 in the first cycle after reset deasserts.
  - Reset during FLUSH drops flush_req immediately and leaves the seed unchanged at SEED_RESET.
- The seed changes only in LATCH, so no in-flight request ever sees two seeds.

Optional Feature:
- Macro: RM_SEED_PARITY_EN.
- Defined:
  - Add a stored even-parity bit over the seed, written in LATCH and at reset.
  - Add output seed_par_err (1 bit, registered): high in any cycle where ^seed != stored parity.
  - seed_par_err is sticky until reset.
  - While seed_par_err is high, the block behaves as if reseed_req were asserted whenever in IDLE.
- Undefined: no parity bit, no seed_par_err port, no forced reseed.

Decomposition:
- Shared defines package:
  - typedef rm_seed_t (logic[SEED_W-1:0]).
  - typedef rm_state_t enum {IDLE, DRAIN, FLUSH, LATCH}.
  - Constants RM_IDX_W and RM_TAG_W.
- One sub-module, rm_index_hash: combinational tf6/tf8/key/rot computation, instantiated in stage 1.
- The FSM and the pipeline registers stay in rm_index_map.

Test Plan:
- Mapping at default seed:
  - seed=0, tag=0, index=5 -> resp_index=5 exactly 2 cycles after acceptance.
  - Back-to-back indices 0..63 -> 64 consecutive responses, a permutation of 0..63.
- Mapping with a loaded seed: reseed with rand_i=16'h0103, then tag=0, index=6'h05 -> rot=1, key=3, resp_index=6'h09.
- Reseed with traffic in flight: 2 requests in flight, then reseed_req -> both respond with the old seed; req_ready=0 from the next cycle; flush_req rises once the pipeline is empty.
- Flush handshake:
  - flush_done 5 cycles after flush_req -> exactly one cycle of reseed_done.
  - seed equals rand_i sampled in that cycle; req_ready=1 the cycle after.
- Ignored events:
  - Second reseed_req during FLUSH -> no extra reseed.
  - Stray flush_done in IDLE -> no state change.
- Reset mid-FLUSH -> flush_req=0 and resp_valid=0 immediately; seed=SEED_RESET; the next request maps with the reset seed.
- With RM_SEED_PARITY_EN: force a seed bit flip -> seed_par_err=1 next cycle, then an automatic DRAIN/FLUSH/LATCH sequence.
